// File: rtl/mas_issue_pkg.sv
// Shared types for the ALU command issuer: ALU opcode, FIFO entry and FSM state.
package mas_issue_pkg;

  // ALU operand/result width shared with mas_alu_top.
  localparam int MAS_BLEN = 32;

  // Widest tag the FIFO entry can carry; narrower TAGW values use the low bits.
  localparam int MAS_ISSUE_TAGW_MAX = 16;

  typedef enum logic [2:0] {
    MAS_ALU_ADD = 3'd0,
    MAS_ALU_SUB = 3'd1,
    MAS_ALU_AND = 3'd2,
    MAS_ALU_OR  = 3'd3,
    MAS_ALU_XOR = 3'd4
  } type_mas_alu_cmd;

  typedef struct packed {
    type_mas_alu_cmd               op;
    logic [MAS_BLEN-1:0]           op1;
    logic [MAS_BLEN-1:0]           op2;
    logic [MAS_ISSUE_TAGW_MAX-1:0] tag;
  } type_mas_issue_entry;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } type_mas_issue_state;

endpackage

// File: rtl/mas_issue_fifo.sv
// Synchronous FIFO for issuer commands. Pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter.
module mas_issue_fifo
  import mas_issue_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = type_mas_issue_entry
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t wr_data,
  input  logic   pop,
  output entry_t rd_data,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      mem [DEPTH];

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; push/pop are gated so a misbehaving caller cannot corrupt state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mas_alu_issuer.sv
// Issues queued ALU commands one at a time to mas_alu_top, returns the result
// with its tag, and converts a missing mas_alu_ready into an error response.
module mas_alu_issuer
  import mas_issue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAGW    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  type_mas_alu_cmd     cmd_op,
  input  logic [MAS_BLEN-1:0] cmd_op1,
  input  logic [MAS_BLEN-1:0] cmd_op2,
  input  logic [TAGW-1:0]     cmd_tag,
  output logic                mas_alu_req,
  output type_mas_alu_cmd     mas_alu_cmd,
  output logic [MAS_BLEN-1:0] mas_alu_op1,
  output logic [MAS_BLEN-1:0] mas_alu_op2,
  input  logic                mas_alu_ready,
  input  logic [MAS_BLEN-1:0] mas_alu_res,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [MAS_BLEN-1:0] rsp_res,
  output logic [TAGW-1:0]     rsp_tag,
  output logic                rsp_err
);

  // Watchdog only has to reach TIMEOUT-1.
  localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  type_mas_issue_state state_q;
  type_mas_issue_state state_d;

  type_mas_issue_entry fifo_wr;
  type_mas_issue_entry fifo_head;
  type_mas_issue_entry issue_p0;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;

  logic [WDW-1:0]      wd_q;
  logic                wd_expired;

  logic [MAS_BLEN-1:0] rsp_res_p1;
  logic [TAGW-1:0]     rsp_tag_p1;
  logic                rsp_err_p1;

  // Tag bits above TAGW are zero padding in the shared entry struct.
  logic                tag_hi_unused;
  assign tag_hi_unused = ^(issue_p0.tag >> TAGW);

  // cmd_ready is forced low while reset is asserted so the producer sees a clean 0.
  assign cmd_ready  = !fifo_full && !rst;
  assign fifo_push  = cmd_valid && cmd_ready;
  assign fifo_wr    = '{op: cmd_op, op1: cmd_op1, op2: cmd_op2,
                        tag: MAS_ISSUE_TAGW_MAX'(cmd_tag)};
  assign wd_expired = (wd_q == WDW'(TIMEOUT - 1));

  mas_issue_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (type_mas_issue_entry)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (fifo_wr),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and FIFO pop; ready wins over an expiring watchdog.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mas_alu_ready || wd_expired) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_GAP;
      end
      ST_GAP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p0: issue register loaded on pop; watchdog counts REQ cycles from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_p0 <= '0;
      wd_q     <= '0;
    end else begin
      if (fifo_pop) issue_p0 <= fifo_head;
      wd_q <= (state_q == ST_REQ) ? wd_q + 1'b1 : '0;
    end
  end

  // Stage p1: response capture, written only when leaving REQ so it stays stable in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_res_p1 <= '0;
      rsp_tag_p1 <= '0;
      rsp_err_p1 <= 1'b0;
    end else if (state_q == ST_REQ) begin
      if (mas_alu_ready) begin
        rsp_res_p1 <= mas_alu_res;
        rsp_tag_p1 <= issue_p0.tag[TAGW-1:0];
        rsp_err_p1 <= 1'b0;
      end else if (wd_expired) begin
        rsp_res_p1 <= '0;
        rsp_tag_p1 <= issue_p0.tag[TAGW-1:0];
        rsp_err_p1 <= 1'b1;
      end
    end
  end

  assign mas_alu_req = (state_q == ST_REQ);
  assign mas_alu_cmd = issue_p0.op;
  assign mas_alu_op1 = issue_p0.op1;
  assign mas_alu_op2 = issue_p0.op2;

  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_res     = rsp_res_p1;
  assign rsp_tag     = rsp_tag_p1;
  assign rsp_err     = rsp_err_p1;

endmodule

// File: tb/tb_mas_alu_issuer.sv
// Self-checking bench for mas_alu_issuer: directed scenarios plus a randomized
// phase, all compared against a transaction-level queue model of the issuer.
module tb_mas_alu_issuer;
  import mas_issue_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TAGW    = 4;
  localparam int TIMEOUT = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid;
  logic                cmd_ready;
  type_mas_alu_cmd     cmd_op;
  logic [MAS_BLEN-1:0] cmd_op1;
  logic [MAS_BLEN-1:0] cmd_op2;
  logic [TAGW-1:0]     cmd_tag;
  logic                mas_alu_req;
  type_mas_alu_cmd     mas_alu_cmd;
  logic [MAS_BLEN-1:0] mas_alu_op1;
  logic [MAS_BLEN-1:0] mas_alu_op2;
  logic                mas_alu_ready;
  logic [MAS_BLEN-1:0] mas_alu_res;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [MAS_BLEN-1:0] rsp_res;
  logic [TAGW-1:0]     rsp_tag;
  logic                rsp_err;

  always #5 clk = ~clk;

  mas_alu_issuer #(.DEPTH(DEPTH), .TAGW(TAGW), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_op1       (cmd_op1),
    .cmd_op2       (cmd_op2),
    .cmd_tag       (cmd_tag),
    .mas_alu_req   (mas_alu_req),
    .mas_alu_cmd   (mas_alu_cmd),
    .mas_alu_op1   (mas_alu_op1),
    .mas_alu_op2   (mas_alu_op2),
    .mas_alu_ready (mas_alu_ready),
    .mas_alu_res   (mas_alu_res),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_res       (rsp_res),
    .rsp_tag       (rsp_tag),
    .rsp_err       (rsp_err)
  );

  // A command as the bench sees it; lat is how many REQ cycles the modelled
  // ALU waits before answering (lat >= TIMEOUT means it never answers).
  typedef struct {
    type_mas_alu_cmd     op;
    logic [MAS_BLEN-1:0] op1;
    logic [MAS_BLEN-1:0] op2;
    logic [TAGW-1:0]     tag;
    int                  lat;
  } txn_t;

  txn_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cur_lat  = 0;
  bit   stray_en = 1'b0;
  bit   prev_req = 1'b0;
  bit   prev_rv  = 1'b0;
  int   req_cnt  = 0;
  int   gap_cnt  = 0;

  function automatic logic [MAS_BLEN-1:0] alu_f(type_mas_alu_cmd op,
                                                logic [MAS_BLEN-1:0] a,
                                                logic [MAS_BLEN-1:0] b);
    case (op)
      MAS_ALU_ADD: return a + b;
      MAS_ALU_SUB: return a - b;
      MAS_ALU_AND: return a & b;
      MAS_ALU_OR:  return a | b;
      MAS_ALU_XOR: return a ^ b;
      default:     return '0;
    endcase
  endfunction

  function automatic bit answered(txn_t t);
    return t.lat < TIMEOUT;
  endfunction

  function automatic int exp_cycles(txn_t t);
    return answered(t) ? t.lat + 1 : TIMEOUT;
  endfunction

  function automatic logic [MAS_BLEN-1:0] exp_res(txn_t t);
    return answered(t) ? alu_f(t.op, t.op1, t.op2) : '0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record what the DUT sees at the edge, advance, check the new
  // outputs against the model, then play the ALU side for the new cycle.
  task automatic tick();
    bit   push_f, acc_f, rdy_f, rst_f;
    txn_t nt, h;
    @(negedge clk);
    rst_f  = rst;
    push_f = cmd_valid && cmd_ready && !rst;
    acc_f  = rsp_valid && rsp_ready;
    rdy_f  = mas_alu_req && mas_alu_ready;
    nt     = '{cmd_op, cmd_op1, cmd_op2, cmd_tag, cur_lat};
    @(posedge clk);
    #1;
    if (rst_f) begin
      exp_q.delete();
      gap_cnt = 0;
      req_cnt = 0;
      chk("rst_req", mas_alu_req, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
    end else begin
      if (push_f) exp_q.push_back(nt);
      if (acc_f) begin
        if (exp_q.size() != 0) h = exp_q.pop_front();
        gap_cnt = 2;
      end
      if (rdy_f) begin
        chk("ready_to_rsp_valid", rsp_valid, 1);
        chk("ready_to_req_low", mas_alu_req, 0);
      end
      if (gap_cnt > 0) begin
        chk("gap_req", mas_alu_req, 0);
        chk("gap_rsp_valid", rsp_valid, 0);
        gap_cnt--;
      end
      chk("req_rsp_exclusive", mas_alu_req & rsp_valid, 0);
      if (mas_alu_req === 1'b1) begin
        if (!prev_req) req_cnt = 0;
        req_cnt++;
        chk("req_has_cmd", exp_q.size() != 0, 1);
        chk("req_within_timeout", req_cnt <= TIMEOUT, 1);
        if (exp_q.size() != 0) begin
          h = exp_q[0];
          chk("alu_cmd", mas_alu_cmd, h.op);
          chk("alu_op1", mas_alu_op1, h.op1);
          chk("alu_op2", mas_alu_op2, h.op2);
        end
      end
      if (rsp_valid === 1'b1) begin
        chk("rsp_has_cmd", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          h = exp_q[0];
          chk("rsp_res", rsp_res, exp_res(h));
          chk("rsp_tag", rsp_tag, h.tag);
          chk("rsp_err", rsp_err, !answered(h));
          if (!prev_rv) chk("req_cycles", req_cnt, exp_cycles(h));
        end
      end
    end
    // ALU side for the cycle now starting.
    mas_alu_ready = 1'b0;
    mas_alu_res   = $urandom;
    if (!rst && mas_alu_req === 1'b1 && exp_q.size() != 0 && exp_q[0].lat + 1 == req_cnt) begin
      mas_alu_ready = 1'b1;
      mas_alu_res   = alu_f(exp_q[0].op, exp_q[0].op1, exp_q[0].op2);
    end else if (stray_en && mas_alu_req !== 1'b1 && $urandom_range(0, 1) == 1) begin
      mas_alu_ready = 1'b1;
    end
    prev_req = (mas_alu_req === 1'b1);
    prev_rv  = (rsp_valid === 1'b1);
  endtask

  initial begin
    int               n;
    int               got;
    int               r;
    logic [TAGW-1:0]  tags [5];
    logic [MAS_BLEN-1:0] hold_res;
    logic [TAGW-1:0]  hold_tag;
    logic             hold_err;

    rst           = 1'b1;
    cmd_valid     = 1'b0;
    cmd_op        = MAS_ALU_ADD;
    cmd_op1       = '0;
    cmd_op2       = '0;
    cmd_tag       = '0;
    mas_alu_ready = 1'b0;
    mas_alu_res   = '0;
    rsp_ready     = 1'b1;

    // Reset state.
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_res", rsp_res, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_cmd", mas_alu_cmd, 0);
    chk("rst_alu_op1", mas_alu_op1, 0);
    chk("rst_alu_op2", mas_alu_op2, 0);
    rst = 1'b0;
    #1;
    chk("cmd_ready_after_rst", cmd_ready, 1);
    repeat (2) tick();

    // Single ADD 5+3, tag 2.
    cmd_op = MAS_ALU_ADD; cmd_op1 = 5; cmd_op2 = 3; cmd_tag = 2; cur_lat = 1;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("t1_req_n1", mas_alu_req, 0);
    tick();
    chk("t1_req_n2", mas_alu_req, 1);
    for (int i = 0; i < 40 && rsp_valid !== 1'b1; i++) tick();
    chk("t1_rsp_seen", rsp_valid, 1);
    chk("t1_rsp_res", rsp_res, 8);
    chk("t1_rsp_tag", rsp_tag, 2);
    chk("t1_rsp_err", rsp_err, 0);
    repeat (4) tick();

    // Five back-to-back pushes with the consumer stalled.
    rsp_ready = 1'b0;
    cur_lat   = 0;
    for (int i = 0; i < 5; i++) begin
      cmd_op    = type_mas_alu_cmd'($urandom_range(0, 4));
      cmd_op1   = $urandom;
      cmd_op2   = $urandom;
      cmd_tag   = TAGW'(i);
      cmd_valid = 1'b1;
      chk($sformatf("t2_cmd_ready_%0d", i), cmd_ready, 1);
      tick();
    end
    cmd_valid = 1'b0;
    chk("t2_full", cmd_ready, 0);
    for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) tick();
    chk("t2_rsp_pending", rsp_valid, 1);
    hold_res = rsp_res;
    hold_tag = rsp_tag;
    hold_err = rsp_err;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_hold_valid", rsp_valid, 1);
      chk("t2_hold_res", rsp_res, hold_res);
      chk("t2_hold_tag", rsp_tag, hold_tag);
      chk("t2_hold_err", rsp_err, hold_err);
      chk("t2_hold_req", mas_alu_req, 0);
      chk("t2_hold_full", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 200 && got < 5; i++) begin
      if (rsp_valid === 1'b1) begin
        tags[got] = rsp_tag;
        got++;
      end
      tick();
    end
    chk("t2_rsp_count", got, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("t2_order_%0d", i), tags[i], i);
    repeat (4) tick();

    // Dead ALU: watchdog response, then a stray ready pulse in GAP.
    stray_en  = 1'b1;
    cur_lat   = TIMEOUT + 4;
    cmd_op    = MAS_ALU_XOR; cmd_op1 = 32'hdead_beef; cmd_op2 = 32'h1234_5678; cmd_tag = 7;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && mas_alu_req !== 1'b1; i++) tick();
    n = 0;
    while (mas_alu_req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("t3_req_cycles", n, TIMEOUT);
    chk("t3_rsp_valid", rsp_valid, 1);
    chk("t3_rsp_err", rsp_err, 1);
    chk("t3_rsp_res", rsp_res, 0);
    chk("t3_rsp_tag", rsp_tag, 7);
    tick();
    mas_alu_ready = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid === 1'b1 || mas_alu_req === 1'b1) n++;
      tick();
    end
    chk("t3_no_extra_rsp", n, 0);

    // Reset while in REQ with three commands queued.
    stray_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_op    = MAS_ALU_SUB;
      cmd_op1   = $urandom;
      cmd_op2   = $urandom;
      cmd_tag   = TAGW'(8 + i);
      cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    chk("t5_in_req", mas_alu_req, 1);
    rst = 1'b1;
    tick();
    chk("t5_req_after_rst", mas_alu_req, 0);
    chk("t5_rsp_after_rst", rsp_valid, 0);
    rst = 1'b0;
    #1;
    chk("t5_cmd_ready", cmd_ready, 1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rsp_valid === 1'b1 || mas_alu_req === 1'b1) n++;
    end
    chk("t5_quiet_after_rst", n, 0);

    // Randomized traffic, including the TIMEOUT-1 / TIMEOUT latency boundary.
    stray_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_op    = type_mas_alu_cmd'($urandom_range(0, 4));
      cmd_op1   = $urandom;
      cmd_op2   = $urandom;
      cmd_tag   = TAGW'($urandom);
      r         = $urandom_range(0, 7);
      cur_lat   = (r == 0) ? TIMEOUT - 1 : (r == 1) ? TIMEOUT : $urandom_range(0, 3);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) tick();
    chk("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mas_alu_issuer.md
# mas_alu_issuer

Command issuer that drives the request side of `mas_alu_top`. It accepts tagged ALU operations from an upstream producer into a small FIFO, presents them one at a time on the `mas_alu_req`/`mas_alu_cmd`/`mas_alu_op1`/`mas_alu_op2` interface, and waits for `mas_alu_ready`. It then captures `mas_alu_res` and returns it with its tag to a downstream consumer. A watchdog turns a missing `mas_alu_ready` into an error response, so the pipeline never hangs.

## Interface
Parameters:
- `DEPTH`, default 4: command FIFO entries; power of two, at least 2.
- `TAGW`, default 4: tag width.
- `TIMEOUT`, default 16: maximum cycles in REQ without `mas_alu_ready`; at least 2.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  upstream command valid.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_op`  in  `type_mas_alu_cmd`  operation.
- `cmd_op1`, `cmd_op2`  in  `MAS_BLEN` each  operands.
- `cmd_tag`  in  `TAGW`  request tag.
- `mas_alu_req`  out  1  request to ALU.
- `mas_alu_cmd`  out  `type_mas_alu_cmd`  operation to ALU.
- `mas_alu_op1`, `mas_alu_op2`  out  `MAS_BLEN` each  operands to ALU.
- `mas_alu_ready`  in  1  ALU result valid.
- `mas_alu_res`  in  `MAS_BLEN`  ALU result.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  downstream accepts response.
- `rsp_res`  out  `MAS_BLEN`  captured result.
- `rsp_tag`  out  `TAGW`  tag of the completed command.
- `rsp_err`  out  1  response produced by timeout.

## Operation
- Push: `cmd_valid && cmd_ready` writes {op, op1, op2, tag} to the FIFO. `cmd_ready = !full`. There is no bypass: a push into a full FIFO is impossible, even when a pop happens in the same cycle.
- FSM states: IDLE, REQ, RESP, GAP.
  - IDLE: if the FIFO is not empty, pop the head into the issue register and go to REQ. Otherwise stay.
  - REQ: `mas_alu_req` = 1 and the issue register drives the ALU ports, held stable. The watchdog counter is 0 on entry and increments each REQ cycle.
    - If `mas_alu_ready` is sampled 1: capture `mas_alu_res` into `rsp_res`, set `rsp_err` = 0, go to RESP.
    - Else, if the counter equals `TIMEOUT-1`: set `rsp_res` = 0 and `rsp_err` = 1, go to RESP.
  - RESP: `rsp_valid` = 1 and `mas_alu_req` = 0. Go to GAP when `rsp_ready` = 1.
  - GAP: one mandatory cycle with `mas_alu_req` = 0, then IDLE. This lets the ALU FSM return to its idle state before the next request.
- `mas_alu_ready` is ignored outside REQ; a late ready after a timeout is dropped.
- The FIFO keeps accepting pushes in every state.
- Pointers are `log2(DEPTH)+1` bits wide. full = MSBs differ and LSBs are equal; empty = pointers are equal. Pointers wrap modulo 2·`DEPTH`.
- `rsp_res`, `rsp_tag` and `rsp_err` are stable while `rsp_valid` is high.

## Timing
- Reset, with `rst` sampled high: FSM goes to IDLE, the FIFO is emptied, the watchdog is cleared, and the issue and response registers are zeroed.
  - All outputs are 0, including `cmd_ready`.
  - `cmd_ready` is 1 in the first cycle after `rst` drops.
- A reset mid-transaction discards the FIFO contents and any in-flight command; `mas_alu_req` is 0 in the next cycle.
- Minimum latency, empty FIFO: push at cycle N, head visible at N+1 (IDLE pops), `mas_alu_req` = 1 at N+2.
- Ready and response: `mas_alu_ready` sampled at cycle M gives `rsp_valid` = 1 and `mas_alu_req` = 0 at M+1.
- Back-to-back commands: the next `mas_alu_req` rises no earlier than 3 cycles after the response is accepted (RESP→GAP→IDLE→REQ).
- Timeout: if there is no ready, `rsp_valid` with `rsp_err` = 1 is asserted exactly `TIMEOUT` cycles after the first REQ cycle.

## Structure
- `type_mas_alu_cmd` and `MAS_BLEN` come from the shared headers `mas_cmd.svh` and `mas_architecture_description.svh`.
- A FIFO entry struct `type_mas_issue_entry` (op, op1, op2, tag) and the FSM enum `type_mas_issue_state` go in a shared package `mas_issue_pkg`.
- One sub-module: `mas_issue_fifo`, a synchronous FIFO parameterized by `DEPTH` and entry type, with push, pop, full and empty. The FSM and watchdog live in the top.

## Test plan
- Single ADD, op1=5 and op2=3, tag=2: `mas_alu_req` rises 2 cycles after the push; the response has `rsp_res`=8, `rsp_tag`=2, `rsp_err`=0, one cycle after ready.
- Push 5 commands back-to-back with `DEPTH`=4 and `rsp_ready` held low: `cmd_ready` drops after the 4th stored entry (the 1st is popped). Responses then come out in order with tags 0..4 once `rsp_ready` goes high.
- Tie `mas_alu_ready` to 0: `rsp_err`=1 and `rsp_res`=0 exactly 16 cycles after REQ starts. A ready pulse injected in GAP produces no extra response.
- Hold `rsp_ready` low for 10 cycles: `rsp_*` stays stable, `mas_alu_req` stays 0, and no new command is issued.
- Assert `rst` while in REQ with 3 entries queued: the next cycle has `mas_alu_req`=0 and `rsp_valid`=0. There are no responses after reset, and `cmd_ready`=1 once `rst` drops.
